// File: rtl/param_decode_stage.sv
// Decode stage: turns one instruction per cycle into the ID/EX register and resolves BZ in ID.
// Latency 1 cycle accept->out_valid; holds everything while execute stalls, interlocks on load-use.
module param_decode_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int SQUASH_SLOTS   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4+4*REG_ADDR_WIDTH-1:0] instruction,
  input  logic                          in_valid,
  output logic                          id_ready,
  output logic [REG_ADDR_WIDTH-1:0]     reg_addr1,
  output logic [REG_ADDR_WIDTH-1:0]     reg_addr2,
  input  logic [DATA_WIDTH-1:0]         reg_data1,
  input  logic [DATA_WIDTH-1:0]         reg_data2,
  input  logic                          ex_ready,
  output logic                          out_valid,
  output logic [2:0]                    alu_opcode,
  output logic [DATA_WIDTH-1:0]         ex_src1,
  output logic [DATA_WIDTH-1:0]         ex_src2,
  output logic                          memory_we,
  output logic [DATA_WIDTH-1:0]         memory_data,
  output logic                          writeback_en,
  output logic                          writeback_src,
  output logic [REG_ADDR_WIDTH-1:0]     writeback_address,
  output logic                          branch_en,
  output logic [2*REG_ADDR_WIDTH-1:0]   branch_offset,
  output logic                          illegal_instr
);

  localparam int RAW = REG_ADDR_WIDTH;
  localparam int IW  = 4 + 4 * RAW;
  localparam int OW  = 2 * RAW;
  localparam int SXW = DATA_WIDTH - OW;
  localparam logic [2:0] SQ_INIT = 3'(SQUASH_SLOTS);

  localparam logic [3:0] OP_LD = 4'hA;
  localparam logic [3:0] OP_ST = 4'hB;
  localparam logic [3:0] OP_BZ = 4'hC;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t state, state_d;
  logic [2:0] sq_cnt, sq_cnt_d;
  logic       ld_q;

  logic [3:0]            opcode;
  logic [RAW-1:0]        rd, rs1, rs2;
  logic [OW-1:0]         offset;
  logic [DATA_WIDTH-1:0] offset_ext;

  assign opcode     = instruction[IW-1 -: 4];
  assign rd         = instruction[IW-5 -: RAW];
  assign rs1        = instruction[IW-5-RAW -: RAW];
  assign rs2        = instruction[IW-5-2*RAW -: RAW];
  assign offset     = instruction[OW-1:0];
  assign offset_ext = {{SXW{offset[OW-1]}}, offset};

  logic is_rtype, is_illegal, reads_rs1, reads_rs2, reads_rd;
  logic hazard, advance, accept, taken, discard;

  assign is_rtype   = (opcode >= 4'h1) && (opcode <= 4'h8);
  assign is_illegal = (opcode >= 4'hD);
  assign reads_rs1  = is_rtype || (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_BZ);
  assign reads_rs2  = is_rtype;
  assign reads_rd   = (opcode == OP_ST);

  // A load sitting in ID/EX has not produced its data yet; no register is exempt.
  assign hazard = in_valid && out_valid && ld_q &&
                  ((reads_rs1 && (rs1 == writeback_address)) ||
                   (reads_rs2 && (rs2 == writeback_address)) ||
                   (reads_rd  && (rd  == writeback_address)));

  assign advance   = !out_valid || ex_ready;
  assign id_ready  = advance && !hazard;
  assign accept    = in_valid && id_ready;
  assign taken     = (opcode == OP_BZ) && (reg_data1 == '0);
  assign branch_en = accept && (state == RUN) && taken;
  assign discard   = (state == SQUASH) || (opcode == OP_BZ) || is_illegal;

  assign reg_addr1     = rs1;
  assign reg_addr2     = (opcode == OP_ST) ? rd : rs2;
  assign branch_offset = offset;

  always_comb begin
    state_d  = state;
    sq_cnt_d = sq_cnt;
    if (accept) begin
      if (state == SQUASH) begin
        sq_cnt_d = sq_cnt - 3'd1;
        if (sq_cnt <= 3'd1) state_d = RUN;
      end else if (branch_en && (SQ_INIT != 3'd0)) begin
        state_d  = SQUASH;
        sq_cnt_d = SQ_INIT;
      end
    end
  end

  logic                  d_valid, d_mwe, d_wbe, d_wbs, d_ld;
  logic [2:0]            d_alu;
  logic [DATA_WIDTH-1:0] d_src1, d_src2;
  logic [RAW-1:0]        d_wba;

  // Defaults describe a bubble; only a live, non-discarded instruction overrides them.
  always_comb begin
    d_valid = 1'b1;
    d_alu   = 3'd0;
    d_src1  = '0;
    d_src2  = '0;
    d_mwe   = 1'b0;
    d_wbe   = 1'b0;
    d_wbs   = 1'b0;
    d_wba   = '0;
    d_ld    = 1'b0;
    if (!in_valid) begin
      d_valid = 1'b0;
    end else if (!hazard && !discard) begin
      d_src1 = reg_data1;
      d_src2 = reg_data2;
      if (is_rtype) begin
        d_alu = 3'(opcode - 4'h1);
        d_wbe = 1'b1;
        d_wba = rd;
      end else if (opcode == OP_LD) begin
        d_src1 = offset_ext;
        d_wbe  = 1'b1;
        d_wbs  = 1'b1;
        d_wba  = rd;
        d_ld   = 1'b1;
      end else if (opcode == OP_ST) begin
        d_src1 = offset_ext;
        d_src2 = reg_data1;
        d_mwe  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      sq_cnt            <= 3'd0;
      ld_q              <= 1'b0;
      out_valid         <= 1'b0;
      alu_opcode        <= 3'd0;
      ex_src1           <= '0;
      ex_src2           <= '0;
      memory_we         <= 1'b0;
      memory_data       <= '0;
      writeback_en      <= 1'b0;
      writeback_src     <= 1'b0;
      writeback_address <= '0;
      illegal_instr     <= 1'b0;
    end else begin
      state         <= state_d;
      sq_cnt        <= sq_cnt_d;
      illegal_instr <= accept && (state == RUN) && is_illegal;
      if (advance) begin
        out_valid         <= d_valid;
        ld_q              <= d_ld;
        alu_opcode        <= d_alu;
        ex_src1           <= d_src1;
        ex_src2           <= d_src2;
        memory_we         <= d_mwe;
        memory_data       <= reg_data2;
        writeback_en      <= d_wbe;
        writeback_src     <= d_wbs;
        writeback_address <= d_wba;
      end
    end
  end

endmodule

// File: tb/tb_param_decode_stage.sv
// Scoreboard bench for param_decode_stage: expected ID/EX contents queued at drive time, popped on output transfer.
module tb_param_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        in_valid;
  logic        id_ready;
  logic [2:0]  reg_addr1, reg_addr2;
  logic [15:0] reg_data1, reg_data2;
  logic        ex_ready;
  logic        out_valid;
  logic [2:0]  alu_opcode;
  logic [15:0] ex_src1, ex_src2;
  logic        memory_we;
  logic [15:0] memory_data;
  logic        writeback_en, writeback_src;
  logic [2:0]  writeback_address;
  logic        branch_en;
  logic [5:0]  branch_offset;
  logic        illegal_instr;

  always #5 clk = ~clk;

  param_decode_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid), .id_ready(id_ready),
    .reg_addr1(reg_addr1), .reg_addr2(reg_addr2), .reg_data1(reg_data1), .reg_data2(reg_data2),
    .ex_ready(ex_ready), .out_valid(out_valid), .alu_opcode(alu_opcode), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .memory_we(memory_we), .memory_data(memory_data),
    .writeback_en(writeback_en), .writeback_src(writeback_src),
    .writeback_address(writeback_address), .branch_en(branch_en),
    .branch_offset(branch_offset), .illegal_instr(illegal_instr)
  );

  typedef struct {
    logic [2:0]  alu;
    logic [15:0] s1, s2, md;
    logic        mwe, wbe, wbs;
    logic [2:0]  wba;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] alu, input logic [15:0] s1, s2, md,
                              input logic mwe, wbe, wbs, input logic [2:0] wba);
    exp_t e;
    e.alu = alu; e.s1 = s1; e.s2 = s2; e.md = md;
    e.mwe = mwe; e.wbe = wbe; e.wbs = wbs; e.wba = wba;
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
  endfunction

  // Transfer to execute happens at the next rising edge when out_valid && ex_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && ex_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_opcode", 32'(alu_opcode), 32'(e.alu));
        check("ex_src1", 32'(ex_src1), 32'(e.s1));
        check("ex_src2", 32'(ex_src2), 32'(e.s2));
        check("memory_we", 32'(memory_we), 32'(e.mwe));
        check("writeback_en", 32'(writeback_en), 32'(e.wbe));
        check("writeback_src", 32'(writeback_src), 32'(e.wbs));
        if (e.wbe) check("writeback_address", 32'(writeback_address), 32'(e.wba));
        if (e.mwe) check("memory_data", 32'(memory_data), 32'(e.md));
      end
    end
  end

  task automatic send(input logic [15:0] ins, input logic [15:0] d1, d2,
                      output int stalls, output logic br, output logic [5:0] bofs);
    bit done = 0;
    instruction = ins; reg_data1 = d1; reg_data2 = d2; in_valid = 1'b1;
    stalls = 0; br = 1'b0; bofs = '0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (id_ready) begin
        br = branch_en; bofs = branch_offset; done = 1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 32'(id_ready), 32'd1);
  endtask

  int         st;
  logic       br;
  logic [5:0] bo;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; ex_ready = 1'b1;
    instruction = '0; reg_data1 = '0; reg_data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_writeback_en", 32'(writeback_en), 32'd0);
    check("rst_illegal", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // R-type: ADD then SUB
    sb.push_back(mk(3'd0, 16'h3, 16'h4, 16'h4, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h14E0, 16'h0003, 16'h0004, st, br, bo);
    check("add_reg_addr1", 32'(reg_addr1), 32'd3);
    check("add_reg_addr2", 32'(reg_addr2), 32'd4);
    check("add_stalls", 32'(st), 32'd0);
    sb.push_back(mk(3'd1, 16'h9, 16'h5, 16'h5, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h24E0, 16'h0009, 16'h0005, st, br, bo);

    // LD then ST reading rd=1 just loaded: one-cycle interlock
    sb.push_back(mk(3'd0, 16'hFFFE, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 3'd1));
    send(16'hA23E, 16'h0000, 16'h0000, st, br, bo);
    sb.push_back(bubble());
    sb.push_back(mk(3'd0, 16'hFFFE, 16'h0055, 16'h0066, 1'b1, 1'b0, 1'b0, 3'd0));
    send(16'hB23E, 16'h0055, 16'h0066, st, br, bo);
    check("st_reg_addr2", 32'(reg_addr2), 32'd1);
    check("st_stalls", 32'(st), 32'd1);

    // Load-use on rs1
    sb.push_back(mk(3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 3'd5));
    send(16'hAA00, 16'h0000, 16'h0000, st, br, bo);
    sb.push_back(bubble());
    sb.push_back(mk(3'd0, 16'h10, 16'h20, 16'h20, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h1560, 16'h0010, 16'h0020, st, br, bo);
    check("ldu_stalls", 32'(st), 32'd1);

    // Taken BZ squashes the next accepted instruction
    sb.push_back(bubble());
    send(16'hC0C5, 16'h0000, 16'h0000, st, br, bo);
    check("bz_branch_en", 32'(br), 32'd1);
    check("bz_offset", 32'(bo), 32'd5);
    sb.push_back(bubble());
    send(16'h14E0, 16'h0003, 16'h0004, st, br, bo);
    check("squash_branch_en", 32'(br), 32'd0);
    sb.push_back(mk(3'd0, 16'h3, 16'h4, 16'h4, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h14E0, 16'h0003, 16'h0004, st, br, bo);

    // Not-taken BZ: bubble only, no squash
    sb.push_back(bubble());
    send(16'hC0C5, 16'h0007, 16'h0000, st, br, bo);
    check("bznt_branch_en", 32'(br), 32'd0);
    sb.push_back(mk(3'd0, 16'h7, 16'h8, 16'h8, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h14E0, 16'h0007, 16'h0008, st, br, bo);

    // Execute backpressure for 3 cycles
    sb.push_back(mk(3'd0, 16'h11, 16'h22, 16'h22, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h14E0, 16'h0011, 16'h0022, st, br, bo);
    ex_ready = 1'b0;
    instruction = 16'h14E0; reg_data1 = 16'h0033; reg_data2 = 16'h0044; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_id_ready", 32'(id_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_ex_src1", 32'(ex_src1), 32'h11);
      check("hold_ex_src2", 32'(ex_src2), 32'h22);
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    sb.push_back(mk(3'd0, 16'h33, 16'h44, 16'h44, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h14E0, 16'h0033, 16'h0044, st, br, bo);

    // Illegal opcode
    sb.push_back(bubble());
    send(16'hF000, 16'h0001, 16'h0002, st, br, bo);
    in_valid = 1'b0;
    @(negedge clk);
    check("illegal_pulse", 32'(illegal_instr), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("illegal_clear", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1;

    // Reset during squash
    sb.push_back(bubble());
    send(16'hC0C5, 16'h0000, 16'h0000, st, br, bo);
    check("bz2_branch_en", 32'(br), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ex_src1", 32'(ex_src1), 32'd0);
    check("mid_rst_writeback_en", 32'(writeback_en), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    sb.push_back(mk(3'd0, 16'h3, 16'h4, 16'h4, 1'b0, 1'b1, 1'b0, 3'd2));
    send(16'h14E0, 16'h0003, 16'h0004, st, br, bo);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
